// File: rtl/opcode_sequencer_pkg.sv
// Shared definitions for the opcode sequencer.
//   - 5-bit opcode constants used by the sequencer and its users
//   - FSM state encoding (also exported on the debug port)
//   - helper that flags reserved opcodes
package opcode_sequencer_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] OP_NOP   = 5'b00000;
  localparam logic [OP_W-1:0] OP_CALL  = 5'b11000;
  localparam logic [OP_W-1:0] OP_CALL2 = 5'b11001;
  localparam logic [OP_W-1:0] OP_RET   = 5'b11010;
  localparam logic [OP_W-1:0] OP_RET2  = 5'b11011;
  localparam logic [OP_W-1:0] OP_RTI   = 5'b11100;
  localparam logic [OP_W-1:0] OP_RTI2  = 5'b11101;
  localparam logic [OP_W-1:0] OP_INT1  = 5'b11110;
  localparam logic [OP_W-1:0] OP_INT2  = 5'b11111;

  typedef enum logic [2:0] {
    ST_NORMAL = 3'd0,
    ST_CALL2  = 3'd1,
    ST_RET2   = 3'd2,
    ST_RTI2   = 3'd3,
    ST_INT1   = 3'd4,
    ST_INT2   = 3'd5
  } state_t;

  // Second-part and interrupt opcodes are produced internally only; a fetch
  // of any of them is an illegal instruction.
  function automatic logic is_reserved(input logic [OP_W-1:0] op);
    return (op == OP_CALL2) || (op == OP_RET2) || (op == OP_RTI2) ||
           (op == OP_INT1)  || (op == OP_INT2);
  endfunction

endpackage

// File: rtl/opcode_sequencer.sv
// Opcode sequencer: turns fetched opcodes into a registered issue stream for
// the control unit, expanding CALL/RET/RTI into two-part sequences, inserting
// a two-cycle interrupt sequence, and freezing on pipeline stalls.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   fetchedOpCode[4:0]  opcode in the fetch/decode register
//   fetchedValid        fetchedOpCode is a real instruction (0 = bubble)
//   stallIn             hazard stall, freezes the FSM
//   intReq              interrupt request (pulse or level)
//   opCode[4:0]         registered opcode to the control unit
//   pcHold              registered, fetch must not advance while 1
//   issueValid          registered, opCode is a real issue
//   intAck              registered pulse while opCode = OP_INT2
//   illegalOp           registered pulse after a reserved opcode fetch
//   dbg_state           current FSM state
//   dbg_int_pending     sticky interrupt-pending flag
//
// State meaning: CALL2/RET2/RTI2 hold the second part owed at the next edge.
// INT1 is the cycle showing OP_INT1 and INT2 the cycle showing OP_INT2; the
// edge leaving INT2 issues the instruction held in fetch during service.
//
// Handshake: there is no back-pressure on the issue side. When stallIn is
// high at an edge nothing is consumed and a bubble with pcHold=1 is issued;
// otherwise the fetched opcode is consumed at that edge only if the FSM is in
// NORMAL (without a pending interrupt) or INT2.
module opcode_sequencer
  import opcode_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] fetchedOpCode,
  input  logic            fetchedValid,
  input  logic            stallIn,
  input  logic            intReq,
  output logic [OP_W-1:0] opCode,
  output logic            pcHold,
  output logic            issueValid,
  output logic            intAck,
  output logic            illegalOp,
  output state_t          dbg_state,
  output logic            dbg_int_pending
);

  state_t          state, state_nxt;
  logic            int_pending, int_pending_nxt;
  logic [OP_W-1:0] op_nxt;
  logic            hold_nxt, valid_nxt, ack_nxt, illegal_nxt;
  logic            take_fetch;

  always_comb begin
    state_nxt       = state;
    int_pending_nxt = int_pending | intReq;
    op_nxt          = OP_NOP;
    hold_nxt        = 1'b0;
    valid_nxt       = 1'b0;
    ack_nxt         = 1'b0;
    illegal_nxt     = 1'b0;
    take_fetch      = 1'b0;

    if (stallIn) begin
      hold_nxt = 1'b1;
    end else begin
      case (state)
        ST_NORMAL: begin
          // intReq is looked at directly so a single-cycle pulse is
          // serviced at the very edge it is seen.
          if (int_pending || intReq) begin
            op_nxt    = OP_INT1;
            valid_nxt = 1'b1;
            hold_nxt  = 1'b1;
            state_nxt = ST_INT1;
          end else begin
            take_fetch = 1'b1;
          end
        end
        ST_CALL2: begin
          op_nxt    = OP_CALL2;
          valid_nxt = 1'b1;
          state_nxt = ST_NORMAL;
        end
        ST_RET2: begin
          op_nxt    = OP_RET2;
          valid_nxt = 1'b1;
          state_nxt = ST_NORMAL;
        end
        ST_RTI2: begin
          op_nxt    = OP_RTI2;
          valid_nxt = 1'b1;
          state_nxt = ST_NORMAL;
        end
        ST_INT1: begin
          // Clearing wins over a simultaneous request; a request still
          // present in the INT2 cycle re-arms the flag for one more service.
          op_nxt          = OP_INT2;
          valid_nxt       = 1'b1;
          hold_nxt        = 1'b1;
          ack_nxt         = 1'b1;
          int_pending_nxt = 1'b0;
          state_nxt       = ST_INT2;
        end
        ST_INT2: begin
          // Held instruction goes first, even if another request is pending.
          take_fetch = 1'b1;
        end
        default: state_nxt = ST_NORMAL;
      endcase

      if (take_fetch) begin
        state_nxt = ST_NORMAL;
        if (fetchedValid) begin
          if (is_reserved(fetchedOpCode)) begin
            illegal_nxt = 1'b1;
          end else begin
            op_nxt    = fetchedOpCode;
            valid_nxt = 1'b1;
            case (fetchedOpCode)
              OP_CALL: begin hold_nxt = 1'b1; state_nxt = ST_CALL2; end
              OP_RET:  begin hold_nxt = 1'b1; state_nxt = ST_RET2;  end
              OP_RTI:  begin hold_nxt = 1'b1; state_nxt = ST_RTI2;  end
              default: ;
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_NORMAL;
      int_pending <= 1'b0;
      opCode      <= OP_NOP;
      pcHold      <= 1'b0;
      issueValid  <= 1'b0;
      intAck      <= 1'b0;
      illegalOp   <= 1'b0;
    end else begin
      state       <= state_nxt;
      int_pending <= int_pending_nxt;
      opCode      <= op_nxt;
      pcHold      <= hold_nxt;
      issueValid  <= valid_nxt;
      intAck      <= ack_nxt;
      illegalOp   <= illegal_nxt;
    end
  end

  assign dbg_state       = state;
  assign dbg_int_pending = int_pending;

endmodule

// File: doc/opcode_sequencer.md
OPCODE_SEQUENCER -- requirements
Module: opcode_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 fetchedOpCode  input  5  opcode field of the instruction word currently held in the fetch/decode register.
REQ-005 fetchedValid  input  1  fetchedOpCode is a real instruction; 0 means bubble.
REQ-006 stallIn  input  1  hazard stall from the pipeline; freezes the sequencer.
REQ-007 intReq  input  1  external interrupt request, one-cycle pulse or level.
REQ-008 opCode  output  5  registered opcode driven to the control unit.
REQ-009 pcHold  output  1  registered; fetch stage SHALL NOT advance PC or the fetch register while 1.
REQ-010 issueValid  output  1  registered; opCode this cycle is a real (non-bubble) issue.
REQ-011 intAck  output  1  registered one-cycle pulse in the cycle opCode=11111.
REQ-012 illegalOp  output  1  registered one-cycle pulse when a reserved opcode was fetched.

Function
REQ-013 All outputs SHALL be registered; an opcode sampled at edge k SHALL appear on opCode after edge k, giving 1-cycle latency.
REQ-014 FSM states SHALL be NORMAL, CALL2, RET2, RTI2, INT1 and INT2.
REQ-015 In NORMAL, with no interrupt pending and fetchedValid=1, the block SHALL issue fetchedOpCode with issueValid=1.
REQ-016 Fetched 11000 (CALL) SHALL issue 11000 with pcHold=1 and go to CALL2.
REQ-017 CALL2 SHALL issue 11001 with pcHold=0 and return to NORMAL.
REQ-018 Fetched 11010 (RET) SHALL issue 11010 with pcHold=1 and go to RET2; RET2 SHALL issue 11011 with pcHold=0 and return to NORMAL.
REQ-019 Fetched 11100 (RTI) SHALL issue 11100 with pcHold=1 and go to RTI2; RTI2 SHALL issue 11101 with pcHold=0 and return to NORMAL.
REQ-020 Fetched reserved opcodes 11001, 11011, 11101, 11110 and 11111 SHALL issue 00000 with issueValid=0, pulse illegalOp and stay in NORMAL.
REQ-021 With fetchedValid=0 in NORMAL, the block SHALL issue 00000 with issueValid=0 and pcHold=0.
REQ-022 A sticky intPending flag SHALL set on any cycle with intReq=1, including during stalls and second-part states.
REQ-023 intPending SHALL clear on entry to INT2.
REQ-024 An interrupt SHALL be serviced only from NORMAL with stallIn=0, and it SHALL take priority over the fetched opcode.
REQ-025 When an interrupt is serviced, the fetched opcode SHALL NOT be consumed.
REQ-026 INT1 SHALL issue 11110 with pcHold=1; INT2 SHALL issue 11111 with pcHold=1 and intAck=1, then return to NORMAL.
REQ-027 The instruction held during interrupt service SHALL issue in the first NORMAL cycle after INT2.
REQ-028 While stallIn=1, state SHALL NOT change.
REQ-029 While stallIn=1, opCode SHALL be 00000, issueValid=0 and pcHold=1.
REQ-030 After a stall, the pending second part or interrupt cycle SHALL issue once stallIn returns to 0.
REQ-031 An intReq arriving in CALL2, RET2 or RTI2 SHALL be latched and serviced in the next NORMAL cycle, never splitting a two-part sequence.
REQ-032 intReq held high across INT2 SHALL trigger exactly one further service.

Reset
REQ-033 Synchronous reset SHALL force state=NORMAL, intPending=0, opCode=00000, pcHold=0, issueValid=0, intAck=0 and illegalOp=0.
REQ-034 Reset SHALL take priority over stallIn and intReq.
REQ-035 Reset SHALL abandon any two-part sequence in progress without issuing its second part.

Structure
REQ-036 A shared package SHALL hold the opcode constants OP_NOP, OP_CALL, OP_CALL2, OP_RET, OP_RET2, OP_RTI, OP_RTI2, OP_INT1 and OP_INT2.
REQ-037 The same shared package SHALL hold the FSM state encoding.
REQ-038 The block SHALL be a single module with no sub-module.

Verification
REQ-039 CALL: fetch 11000 at cycle 0 -> opCode 11000 with pcHold=1 at cycle 1; opCode 11001 with pcHold=0 at cycle 2.
REQ-040 Interrupt priority: intReq pulse with 01001 fetched -> 11110, then 11111 with intAck=1, then 01001; pcHold=1 during the first two.
REQ-041 Interrupt mid-RET: intReq in the RET2 cycle -> 11010, 11011, 11110, 11111, then the held instruction.
REQ-042 Stall: stallIn=1 for 3 cycles in CALL2 -> three 00000 with pcHold=1, then 11001.
REQ-043 Reserved opcode: fetch 11101 -> opCode 00000, issueValid=0, one illegalOp pulse, state stays NORMAL.
REQ-044 Reset mid-sequence: reset during RTI2 -> next cycle opCode=00000, pcHold=0, intPending=0, and 11101 is never issued.
